// File: rtl/hi_lo_pkg.sv
// Shared encodings for the HI/LO unit: Op codes, control states and the divide step count.
package hi_lo_pkg;

  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 6;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned value.
  function automatic logic [31:0] abs_u32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hi_lo_unit_if.sv
// EX-stage bundle between the pipeline and the HI/LO unit.
interface hi_lo_unit_if;
  logic [2:0]  op;
  logic [31:0] alu_lo;
  logic [31:0] alu_hi;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        div_by_zero;

  modport master (
    output op, alu_lo, alu_hi, rs_data, rt_data, flush,
    input  hi, lo, busy, div_by_zero
  );

  modport slave (
    input  op, alu_lo, alu_hi, rs_data, rt_data, flush,
    output hi, lo, busy, div_by_zero
  );
endinterface

// File: rtl/serial_divider_u32.sv
// Unsigned restoring divider, one quotient bit per clock, 32 steps after start.
module serial_divider_u32
  import hi_lo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      dividend,
  input  logic [31:0]      divisor,
  input  logic             abort,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic [31:0]      quotient,
  output logic [31:0]      remainder
);

  logic             running_reg;
  logic             done_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      quo_reg;
  logic [31:0]      rem_reg;
  logic [31:0]      dsr_reg;

  logic [32:0] partial;
  logic [32:0] trial;
  logic        fits;

  // Dividend bits shift out of the top of quo_reg while quotient bits shift in at the bottom.
  always_comb begin
    partial = {rem_reg, quo_reg[31]};
    trial   = partial - {1'b0, dsr_reg};
    fits    = ~trial[32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dsr_reg     <= '0;
    end else if (abort) begin
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
    end else if (start) begin
      running_reg <= 1'b1;
      done_reg    <= 1'b0;
      count_reg   <= '0;
      quo_reg     <= dividend;
      rem_reg     <= '0;
      dsr_reg     <= divisor;
    end else if (running_reg) begin
      rem_reg   <= fits ? trial[31:0] : partial[31:0];
      quo_reg   <= {quo_reg[30:0], fits};
      count_reg <= count_reg + 1'b1;
      if (count_reg == CNT_W'(DIV_STEPS - 1)) begin
        running_reg <= 1'b0;
        done_reg    <= 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign count     = count_reg;
  assign done      = done_reg;
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/hi_lo_unit.sv
// Architectural HI/LO pair: MULT capture, MTHI/MTLO, and iterative DIV/DIVU with a Busy stall.
module hi_lo_unit
  import hi_lo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hi_lo_unit_if.slave  bus
);

  state_e                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   hi_reg, hi_next;
  logic [DATA_WIDTH-1:0]   lo_reg, lo_next;
  logic                    dbz_reg, dbz_next;
  logic                    q_neg_reg, q_neg_next;
  logic                    r_neg_reg, r_neg_next;

  logic                    div_start;
  logic                    div_abort;
  logic                    div_done;
  logic [CNT_W-1:0]        div_count;
  logic [DATA_WIDTH-1:0]   div_quo;
  logic [DATA_WIDTH-1:0]   div_rem;
  logic                    is_signed;
  logic [DATA_WIDTH-1:0]   dividend_mag;
  logic [DATA_WIDTH-1:0]   divisor_mag;

  assign is_signed    = (bus.op == OP_DIV);
  assign dividend_mag = is_signed ? abs_u32(bus.rs_data) : bus.rs_data;
  assign divisor_mag  = is_signed ? abs_u32(bus.rt_data) : bus.rt_data;

  serial_divider_u32 u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .abort     (div_abort),
    .count     (div_count),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
      dbz_reg   <= 1'b0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      dbz_reg   <= dbz_next;
      q_neg_reg <= q_neg_next;
      r_neg_reg <= r_neg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    dbz_next   = 1'b0;
    q_neg_next = q_neg_reg;
    r_neg_next = r_neg_reg;
    div_start  = 1'b0;
    div_abort  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!bus.flush) begin
          case (bus.op)
            OP_MULT: begin
              hi_next = bus.alu_hi;
              lo_next = bus.alu_lo;
            end
            OP_MTHI: hi_next = bus.rs_data;
            OP_MTLO: lo_next = bus.rs_data;
            OP_DIV, OP_DIVU: begin
              if (bus.rt_data == '0) begin
                hi_next  = bus.rs_data;
                lo_next  = '1;
                dbz_next = 1'b1;
              end else begin
                div_start  = 1'b1;
                q_neg_next = is_signed & (bus.rs_data[31] ^ bus.rt_data[31]);
                r_neg_next = is_signed & bus.rs_data[31];
                state_next = DIV;
              end
            end
            default: ;
          endcase
        end
      end

      DIV: begin
        if (bus.flush) begin
          div_abort  = 1'b1;
          state_next = IDLE;
        end else if (div_count == CNT_W'(DIV_STEPS - 1)) begin
          state_next = FIX;
        end
      end

      FIX: begin
        // A flush here drops the result write entirely.
        if (bus.flush) begin
          div_abort = 1'b1;
        end else if (div_done) begin
          lo_next = q_neg_reg ? (~div_quo + 1'b1) : div_quo;
          hi_next = r_neg_reg ? (~div_rem + 1'b1) : div_rem;
        end
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Directed bench for hi_lo_unit: vector table plus hand sequences for stall, flush and reset.
module tb_hi_lo_unit;
  import hi_lo_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   n;

  hi_lo_unit_if bus ();

  hi_lo_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] ahi;
    logic [31:0] alo;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ebusy;
    logic        edbz;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Presents an op for exactly one cycle; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] ahi, input logic [31:0] alo,
                       input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.op      = op;
    bus.alu_hi  = ahi;
    bus.alu_lo  = alo;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(negedge clk);
    bus.op = OP_NONE;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    bus.op = OP_NONE; bus.alu_hi = '0; bus.alu_lo = '0;
    bus.rs_data = '0; bus.rt_data = '0; bus.flush = 1'b0;

    vecs[0]  = '{OP_MULT, 32'h1, 32'h80000000, 32'h0, 32'h0, 32'h1, 32'h80000000, 0, 1'b0};
    vecs[1]  = '{OP_MTHI, 32'h0, 32'h0, 32'h11, 32'h0, 32'h11, 32'h80000000, 0, 1'b0};
    vecs[2]  = '{OP_MTLO, 32'h0, 32'h0, 32'h22, 32'h0, 32'h11, 32'h22, 0, 1'b0};
    vecs[3]  = '{OP_DIV,  32'h0, 32'h0, 32'd5, 32'h0, 32'd5, 32'hFFFFFFFF, 0, 1'b1};
    vecs[4]  = '{OP_DIVU, 32'h0, 32'h0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0};
    vecs[5]  = '{OP_DIV,  32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
    vecs[6]  = '{OP_DIV,  32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0};
    vecs[7]  = '{3'b110,  32'h5, 32'h6, 32'hAAAA, 32'h0, 32'h0, 32'h80000000, 0, 1'b0};
    vecs[8]  = '{OP_DIVU, 32'h0, 32'h0, 32'd7, 32'd100, 32'd7, 32'd0, 33, 1'b0};
    vecs[9]  = '{OP_DIV,  32'h0, 32'h0, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 33, 1'b0};
    vecs[10] = '{OP_DIVU, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 33, 1'b0};
    vecs[11] = '{OP_DIVU, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1'b1};
    vecs[12] = '{OP_DIV,  32'h0, 32'h0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 33, 1'b0};
    vecs[13] = '{3'b111,  32'h9, 32'h9, 32'h9, 32'h9, 32'hFFFFFFFE, 32'd14, 0, 1'b0};

    @(negedge clk);
    @(negedge clk);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_dbz", {31'b0, bus.div_by_zero}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].ahi, vecs[i].alo, vecs[i].rs, vecs[i].rt);
      check($sformatf("v%0d_dbz", i), {31'b0, bus.div_by_zero}, {31'b0, vecs[i].edbz});
      wait_idle(n);
      check($sformatf("v%0d_busy_cycles", i), n, vecs[i].ebusy);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].ehi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].elo);
      if (vecs[i].edbz) begin
        @(negedge clk);
        check($sformatf("v%0d_dbz_drop", i), {31'b0, bus.div_by_zero}, 32'h0);
      end
      $display("vec %0d op=%0b rs=0x%08h rt=0x%08h -> hi=0x%08h lo=0x%08h busy_cycles=%0d",
               i, vecs[i].op, vecs[i].rs, vecs[i].rt, bus.hi, bus.lo, n);
    end

    // MTHI during Busy is ignored; Hi/Lo hold their old values mid-divide.
    issue(OP_DIVU, 32'h0, 32'h0, 32'd100, 32'd7);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (n == 2) begin
        check("stall_hold_hi", bus.hi, 32'hFFFFFFFE);
        check("stall_hold_lo", bus.lo, 32'd14);
      end
      if (n == 5) begin bus.op = OP_MTHI; bus.rs_data = 32'hDEADBEEF; end
      if (n == 6) bus.op = OP_NONE;
      @(negedge clk);
    end
    check("stall_busy_cycles", n, 33);
    check("stall_hi", bus.hi, 32'd2);
    check("stall_lo", bus.lo, 32'd14);
    $display("seq stall: hi=0x%08h lo=0x%08h busy_cycles=%0d", bus.hi, bus.lo, n);

    // Flush on busy cycle 10 aborts the divide without touching Hi/Lo.
    issue(OP_MTHI, 32'h0, 32'h0, 32'hAAAA, 32'h0);
    issue(OP_MTLO, 32'h0, 32'h0, 32'hBBBB, 32'h0);
    issue(OP_DIVU, 32'h0, 32'h0, 32'd1000, 32'd3);
    n = 1;
    while (bus.busy && n < 10) begin n++; @(negedge clk); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_div_busy", {31'b0, bus.busy}, 32'h0);
    check("flush_div_hi", bus.hi, 32'hAAAA);
    check("flush_div_lo", bus.lo, 32'hBBBB);
    issue(OP_DIVU, 32'h0, 32'h0, 32'd9, 32'd3);
    wait_idle(n);
    check("after_flush_busy_cycles", n, 33);
    check("after_flush_hi", bus.hi, 32'd0);
    check("after_flush_lo", bus.lo, 32'd3);
    $display("seq flush_div: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

    // Flush in FIX (busy cycle 33) beats the completing write.
    issue(OP_DIVU, 32'h0, 32'h0, 32'd50, 32'd5);
    n = 1;
    while (bus.busy && n < 33) begin n++; @(negedge clk); end
    check("fix_reached_busy", {31'b0, bus.busy}, 32'h1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_fix_busy", {31'b0, bus.busy}, 32'h0);
    check("flush_fix_hi", bus.hi, 32'd0);
    check("flush_fix_lo", bus.lo, 32'd3);
    $display("seq flush_fix: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

    // Flush in IDLE drops the op presented that cycle.
    @(negedge clk);
    bus.op = OP_MTHI; bus.rs_data = 32'h5555; bus.flush = 1'b1;
    @(negedge clk);
    bus.op = OP_NONE; bus.flush = 1'b0;
    check("flush_idle_hi", bus.hi, 32'd0);
    $display("seq flush_idle: hi=0x%08h", bus.hi);

    // Asynchronous reset mid-divide, asserted between clock edges.
    issue(OP_MTHI, 32'h0, 32'h0, 32'h77, 32'h0);
    issue(OP_DIVU, 32'h0, 32'h0, 32'd1000, 32'd3);
    n = 1;
    while (bus.busy && n < 20) begin n++; @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    check("areset_hi", bus.hi, 32'h0);
    check("areset_lo", bus.lo, 32'h0);
    check("areset_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_MTLO, 32'h0, 32'h0, 32'h1234, 32'h0);
    check("post_reset_lo", bus.lo, 32'h1234);
    check("post_reset_busy", {31'b0, bus.busy}, 32'h0);
    $display("seq areset: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
- Owns the architectural HI/LO register pair for the EX stage and sits directly downstream of the 32-bit ALU.
- Captures the ALU's 64-bit multiply result (low and high halves), services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.
- Implements DIV/DIVU as an iterative 1-bit-per-cycle divider, with a Busy stall to the hazard unit.

Parameters:
- DATA_WIDTH, 32, operand/register width; the only supported value is 32.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Op  in  3  000 none, 001 MULT/MULTU capture, 010 MTHI, 011 MTLO, 100 DIV, 101 DIVU, 110/111 reserved.
- ALULo  in  32  low product word from the ALU result.
- ALUHi  in  32  high product word from the ALU hi result.
- RsData  in  32  dividend / MTHI / MTLO source.
- RtData  in  32  divisor.
- Flush  in  1  aborts any in-flight divide.
- Hi  out  32  HI register.
- Lo  out  32  LO register.
- Busy  out  1  divide in progress; the pipeline must stall MF*/MT*/MULT*/DIV*.
- DivByZero  out  1  one-cycle pulse on a divide with RtData==0.

Behaviour:
- Reset (Rst=0, async): Hi=0, Lo=0, Busy=0, DivByZero=0, state=IDLE, counter=0. A reset mid-divide discards the divide.
- Op is sampled only in IDLE with Flush=0. Op!=000 for one cycle means one instruction.
- Ops presented while Busy=1 are ignored. Reserved codes are ignored.
- MULT (001): Hi<=ALUHi, Lo<=ALULo at the sampling edge. Latency 1, Busy stays 0.
- MTHI (010): Hi<=RsData. MTLO (011): Lo<=RsData. Latency 1, the other register is unchanged.
- DIV/DIVU with RtData!=0:
  - Edge E0 latches the operands. For DIV it latches |Rs| and |Rt|, plus the quotient sign (Rs[31]^Rt[31]) and the remainder sign (Rs[31]).
  - State goes to DIV, counter=0, Busy=1.
- DIV state: one restoring-division step per edge (shift remainder:dividend left 1, trial subtract, set quotient bit). Edges E1..E32 perform these steps, and E32 moves to FIX.
- FIX state (edge E33):
  - For DIV, negate the quotient and/or remainder per the latched signs.
  - Write Lo<=quotient, Hi<=remainder.
  - State goes to IDLE, Busy=0.
  - Busy is high for exactly 33 cycles, and Hi/Lo are visible in the cycle after Busy falls.
- Busy is a decode of the state register (state!=IDLE), with no combinational path from Op.
- Hi/Lo hold their old values throughout a divide.
- Divide by zero (DIV/DIVU, RtData==0):
  - Single-cycle completion with no Busy.
  - Hi<=RsData, Lo<=32'hFFFFFFFF.
  - DivByZero=1 for the following cycle only.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. This falls out of the unsigned magnitude path and needs no special case.
- Flush=1 in DIV or FIX: the next edge returns to IDLE and Busy=0. Hi/Lo are unchanged and a pending FIX write is dropped.
- Flush=1 in IDLE: Op is dropped that cycle.
- Flush and a completing FIX on the same edge: Flush wins.
- DivByZero deasserts every cycle that it is not set.

Decomposition:
- Package hi_lo_pkg holds:
  - the Op encodings (OP_NONE, OP_MULT, OP_MTHI, OP_MTLO, OP_DIV, OP_DIVU);
  - the state enum (IDLE, DIV, FIX);
  - DIV_STEPS=32.
- One natural sub-module, serial_divider_u32: an unsigned restoring core with ports start, dividend, divisor, abort, step counter, done, quotient, remainder.
- hi_lo_unit wraps the core with sign handling, the HI/LO registers and the Op decode.

Test Plan:
- MULT capture: ALUHi=0x00000001, ALULo=0x80000000, Op=001 for 1 cycle -> next cycle Hi=0x00000001, Lo=0x80000000, Busy never asserts.
- DIVU: Rs=100, Rt=7, Op=101 -> Busy high exactly 33 cycles, then Lo=14, Hi=2. MTHI issued during Busy (RsData=0xDEADBEEF) is ignored, Hi=2 after completion.
- DIV signed: Rs=0xFFFFFFF9 (-7), Rt=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Overflow case Rs=0x80000000, Rt=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divide by zero: Hi=0x11, Lo=0x22 preloaded via MTHI/MTLO, then DIV Rs=5, Rt=0 -> next cycle Hi=5, Lo=0xFFFFFFFF, DivByZero=1 for one cycle, Busy=0 throughout.
- Flush: start DIVU 1000/3, assert Flush on Busy cycle 10 -> Busy=0 next cycle, Hi/Lo keep prior values, and a new DIVU 9/3 then gives Lo=3, Hi=0.
- Async reset: drive Rst=0 mid-divide (cycle 20) between clock edges -> Hi=0, Lo=0, Busy=0 immediately. After release, MTLO RsData=0x1234 -> Lo=0x1234 next cycle.
